// File: rtl/mac_pipe_unit_if.sv
// Operand/result bus of the arithmetic pipeline. The master drives operands
// and mode; the slave (the pipeline) returns the result and status.
interface mac_pipe_unit_if #(
  parameter int DATA_W  = 32,
  parameter int GUARD_W = 8
);
  localparam int ACC_W = DATA_W + GUARD_W;

  logic              in_valid;
  logic [1:0]        mode;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              out_valid;
  logic [ACC_W-1:0]  Result;
  logic              sat;
  logic              acc_busy;

  modport master (
    output in_valid, mode, A, B,
    input  out_valid, Result, sat, acc_busy
  );

  modport slave (
    input  in_valid, mode, A, B,
    output out_valid, Result, sat, acc_busy
  );
endinterface

// File: rtl/mac_pipe_unit.sv
// Two-stage add / multiply / multiply-accumulate pipeline with a guarded,
// saturating accumulator. Stage 1 forms the term (sum or clipped product),
// stage 2 applies it to the result register and, for MAC/CLR, the accumulator.
// Assumes 1 <= GUARD_W <= DATA_W so the product is at least as wide as the
// accumulator and an ADD term never overflows it.
module mac_pipe_unit #(
  parameter int DATA_W  = 32,
  parameter int GUARD_W = 8
) (
  input  logic           clk,
  input  logic           nRST,
  mac_pipe_unit_if.slave bus
);
  localparam int ACC_W  = DATA_W + GUARD_W;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_MUL = 2'b01,
    MODE_MAC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  localparam logic [ACC_W-1:0]  ACC_ONES   = '1;
  localparam logic [PROD_W-1:0] PROD_LIMIT = PROD_W'(ACC_ONES);

  mode_e             mode_in;
  logic [DATA_W:0]   add_sum;
  logic [PROD_W-1:0] prod;
  logic              prod_ovf;
  logic [ACC_W-1:0]  term_d;
  logic              sat_d;

  // vld_pipe[0]: stage-1 valid, vld_pipe[1]: result valid
  logic [1:0]        vld_pipe;
  mode_e             mode_s1;
  logic [ACC_W-1:0]  term_s1;
  logic              sat_s1;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    mac_sum;
  logic [ACC_W-1:0]  result_q;
  logic              sat_q;

  assign mode_in = mode_e'(bus.mode);

  // Stage-1 term: ADD is zero-extended, products above the accumulator range clip to all ones
  always_comb begin
    add_sum  = {1'b0, bus.A} + {1'b0, bus.B};
    prod     = PROD_W'(bus.A) * PROD_W'(bus.B);
    prod_ovf = prod > PROD_LIMIT;
    term_d   = '0;
    sat_d    = 1'b0;
    case (mode_in)
      MODE_ADD: term_d = ACC_W'(add_sum);
      MODE_MUL,
      MODE_MAC: begin
        term_d = prod_ovf ? ACC_ONES : prod[ACC_W-1:0];
        sat_d  = prod_ovf;
      end
      default:  term_d = '0;
    endcase
  end

  // Valid shift register; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (!nRST) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[0], bus.in_valid};
  end

  // Stage-1 payload, loaded only for accepted inputs
  always_ff @(posedge clk) begin
    if (!nRST) begin
      mode_s1 <= MODE_ADD;
      term_s1 <= '0;
      sat_s1  <= 1'b0;
    end else if (bus.in_valid) begin
      mode_s1 <= mode_in;
      term_s1 <= term_d;
      sat_s1  <= sat_d;
    end
  end

  // Carry out of this sum means the accumulator would wrap
  assign mac_sum = {1'b0, acc} + {1'b0, term_s1};

  // Stage 2: the only place the accumulator is read or written, so back-to-back MACs chain
  always_ff @(posedge clk) begin
    if (!nRST) begin
      acc      <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else if (vld_pipe[0]) begin
      case (mode_s1)
        MODE_ADD,
        MODE_MUL: begin
          result_q <= term_s1;
          sat_q    <= sat_s1;
        end
        MODE_MAC: begin
          if (mac_sum[ACC_W]) begin
            acc      <= ACC_ONES;
            result_q <= ACC_ONES;
            sat_q    <= 1'b1;
          end else begin
            acc      <= mac_sum[ACC_W-1:0];
            result_q <= mac_sum[ACC_W-1:0];
            sat_q    <= sat_s1;
          end
        end
        default: begin
          acc      <= '0;
          result_q <= '0;
          sat_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = vld_pipe[1];
  assign bus.Result    = result_q;
  assign bus.sat       = sat_q;
  assign bus.acc_busy  = vld_pipe[0] && (mode_s1 == MODE_MAC || mode_s1 == MODE_CLR);
endmodule

// File: tb/tb_mac_pipe_unit.sv
// Directed bench for mac_pipe_unit: isolated single operations from a table,
// then back-to-back streams and a reset that lands on an in-flight operation.
// Operands presented after edge N are captured at N+1 and appear after N+2.
module tb_mac_pipe_unit;
  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] MUL = 2'b01;
  localparam logic [1:0] MAC = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [39:0] res;
    logic        sat;
  } vec_t;

  logic clk;
  logic nRST;
  int   total;
  int   passed;

  vec_t tbl[$];
  vec_t seq[$];

  mac_pipe_unit_if #(.DATA_W(32), .GUARD_W(8)) bus ();

  mac_pipe_unit #(.DATA_W(32), .GUARD_W(8)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] m, input logic [31:0] a,
                              input logic [31:0] b, input logic [39:0] r,
                              input logic s);
    vec_t v;
    v.mode = m; v.a = a; v.b = b; v.res = r; v.sat = s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] a,
                       input logic [31:0] b);
    bus.in_valid = v;
    bus.mode     = m;
    bus.A        = a;
    bus.B        = b;
  endtask

  // Issue seq[] on consecutive cycles; results must come out on consecutive cycles
  task automatic run_stream(input string tag);
    for (int i = 0; i <= seq.size(); i++) begin
      if (i < seq.size()) drive(1'b1, seq[i].mode, seq[i].a, seq[i].b);
      else                drive(1'b0, ADD, 32'h0, 32'h0);
      tick();
      if (i >= 1) begin
        chk($sformatf("%s[%0d] out_valid", tag, i-1), 64'(bus.out_valid), 64'd1);
        chk($sformatf("%s[%0d] Result", tag, i-1), 64'(bus.Result), 64'(seq[i-1].res));
        chk($sformatf("%s[%0d] sat", tag, i-1), 64'(bus.sat), 64'(seq[i-1].sat));
      end
    end
    tick();
    chk($sformatf("%s tail out_valid", tag), 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    nRST   = 1'b0;
    drive(1'b0, ADD, 32'h0, 32'h0);
    tick();
    tick();
    nRST = 1'b1;

    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset Result", 64'(bus.Result), 64'd0);
    chk("reset sat", 64'(bus.sat), 64'd0);
    chk("reset acc_busy", 64'(bus.acc_busy), 64'd0);

    // Isolated operations; accumulator starts at 0 after reset
    tbl.push_back(mk(ADD, 32'd10, 32'd20, 40'd30, 1'b0));
    tbl.push_back(mk(MUL, 32'd99, 32'd2, 40'd198, 1'b0));
    tbl.push_back(mk(ADD, 32'd80, 32'd90, 40'd170, 1'b0));
    tbl.push_back(mk(MAC, 32'd3, 32'd4, 40'd12, 1'b0));
    tbl.push_back(mk(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1));
    tbl.push_back(mk(ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40'h01_FFFF_FFFE, 1'b0));
    tbl.push_back(mk(MAC, 32'd10, 32'd10, 40'd112, 1'b0));
    tbl.push_back(mk(MUL, 32'h000F_FFFF, 32'h0010_0001, 40'hFF_FFFF_FFFF, 1'b0));
    tbl.push_back(mk(MUL, 32'h0010_0000, 32'h0010_0000, 40'hFF_FFFF_FFFF, 1'b1));
    tbl.push_back(mk(MAC, 32'hFFFF_FFFF, 32'd0, 40'd112, 1'b0));
    tbl.push_back(mk(CLR, 32'd55, 32'd66, 40'd0, 1'b0));
    tbl.push_back(mk(MAC, 32'd3, 32'd4, 40'd12, 1'b0));

    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].mode, tbl[i].a, tbl[i].b);
      tick();
      drive(1'b0, MUL, 32'hDEAD_BEEF, 32'h1234_5678);
      chk($sformatf("v%0d early out_valid", i), 64'(bus.out_valid), 64'd0);
      chk($sformatf("v%0d acc_busy", i), 64'(bus.acc_busy), 64'(tbl[i].mode[1]));
      tick();
      chk($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("v%0d Result", i), 64'(bus.Result), 64'(tbl[i].res));
      chk($sformatf("v%0d sat", i), 64'(bus.sat), 64'(tbl[i].sat));
      tick();
      chk($sformatf("v%0d pulse end", i), 64'(bus.out_valid), 64'd0);
      chk($sformatf("v%0d Result hold", i), 64'(bus.Result), 64'(tbl[i].res));
      chk($sformatf("v%0d sat hold", i), 64'(bus.sat), 64'(tbl[i].sat));
    end

    // Mode changes and chained MACs with no bubbles
    seq.delete();
    seq.push_back(mk(MUL, 32'd99, 32'd2, 40'd198, 1'b0));
    seq.push_back(mk(ADD, 32'd80, 32'd90, 40'd170, 1'b0));
    seq.push_back(mk(CLR, 32'd0, 32'd0, 40'd0, 1'b0));
    seq.push_back(mk(MAC, 32'd80, 32'd90, 40'd7200, 1'b0));
    seq.push_back(mk(MAC, 32'd80, 32'd90, 40'd14400, 1'b0));
    run_stream("chain");

    // Accumulator saturation sticks until CLR
    seq.delete();
    seq.push_back(mk(CLR, 32'd0, 32'd0, 40'd0, 1'b0));
    seq.push_back(mk(MAC, 32'hFFFF_FFFF, 32'hFF, 40'hFE_FFFF_FF01, 1'b0));
    for (int k = 0; k < 4; k++)
      seq.push_back(mk(MAC, 32'hFFFF_FFFF, 32'hFF, 40'hFF_FFFF_FFFF, 1'b1));
    seq.push_back(mk(CLR, 32'd0, 32'd0, 40'd0, 1'b0));
    seq.push_back(mk(MAC, 32'd2, 32'd3, 40'd6, 1'b0));
    seq.push_back(mk(MAC, 32'd5, 32'd5, 40'd31, 1'b0));
    run_stream("satur");

    // Reset lands while a MAC sits in stage 1: it must vanish and acc must clear
    drive(1'b1, MAC, 32'd7, 32'd7);
    tick();
    drive(1'b0, ADD, 32'h0, 32'h0);
    chk("flight acc_busy", 64'(bus.acc_busy), 64'd1);
    nRST = 1'b0;
    tick();
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst Result", 64'(bus.Result), 64'd0);
    chk("rst sat", 64'(bus.sat), 64'd0);
    chk("rst acc_busy", 64'(bus.acc_busy), 64'd0);
    nRST = 1'b1;
    tick();
    chk("post-rst out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("post-rst out_valid 2", 64'(bus.out_valid), 64'd0);
    seq.delete();
    seq.push_back(mk(MAC, 32'd3, 32'd4, 40'd12, 1'b0));
    run_stream("after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
